// File: rtl/mips_io_periph.sv
// mips789 memory-mapped I/O block: 8N1 UART, 32-bit up-timer, 2-digit hex 7-seg,
// LCD/LED control, key inputs and a 3-source vectored interrupt controller.
// Build option: define KEY_IRQ_EN to add key1/key2 interrupt sources and their vector registers.
module mips_io_periph #(
  parameter logic [31:0] BASE         = 32'h0F00_0000,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [31:0] addr,
  input  logic [3:0]  mem_ctl,
  output logic [31:0] dout,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  input  logic        ser_rxd,
  output logic        ser_txd,
  output logic [6:0]  seg7led1,
  output logic [6:0]  seg7led2,
  output logic        led1,
  output logic        led2,
  input  logic        key1,
  input  logic        key2,
  output logic [31:0] irq_addr_o,
  output logic        irq_req_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

  // access decode
  logic is_lw, is_lb, is_sw, is_sb;
  assign is_lw = (mem_ctl == 4'd1);
  assign is_lb = (mem_ctl == 4'd2) || (mem_ctl == 4'd3);
  assign is_sw = (mem_ctl == 4'd4);
  assign is_sb = (mem_ctl == 4'd5);

  logic a_status, a_cmd, a_uart, a_lcd, a_seg, a_tdat, a_tvec, a_k1v, a_k2v;
  assign a_status = (addr == BASE);
  assign a_cmd    = (addr == BASE + 32'h04);
  assign a_uart   = (addr == BASE + 32'h08);
  assign a_lcd    = (addr == BASE + 32'h0C);
  assign a_seg    = (addr == BASE + 32'h10);
  assign a_tdat   = (addr == BASE + 32'h14);
  assign a_tvec   = (addr == BASE + 32'h18);
  assign a_k1v    = (addr == BASE + 32'h1C);
  assign a_k2v    = (addr == BASE + 32'h20);

  logic [31:0] cmd, tmr_vec, timer;
  logic [7:0]  seg7data, rx_byte;
  logic        tx_busy, rx_rdy, key1_s, key2_s;
  logic [1:0]  k1_sync, k2_sync;

  assign lcd_rs = cmd[2];
  assign lcd_rw = cmd[3];
  assign lcd_en = cmd[4];
  assign led1   = cmd[5];
  assign led2   = cmd[6];

  // control/data registers written by stores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd <= '0; seg7data <= '0; lcd_data <= '0; tmr_vec <= '0;
    end else begin
      if (is_sw && a_cmd)  cmd      <= din;
      if (is_sb && a_lcd)  lcd_data <= din[7:0];
      if (is_sb && a_seg)  seg7data <= din[7:0];
      if (is_sw && a_tvec) tmr_vec  <= din;
    end
  end

  // key synchronizers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k1_sync <= '0; k2_sync <= '0;
    end else begin
      k1_sync <= {k1_sync[0], key1};
      k2_sync <= {k2_sync[0], key2};
    end
  end
  assign key1_s = k1_sync[1];
  assign key2_s = k2_sync[1];

  // registered load data, zero when no load hits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout <= '0;
    else begin
      dout <= '0;
      if (is_lw && a_status) dout <= {28'b0, rx_rdy, tx_busy, key1_s, key2_s};
      if (is_lw && a_cmd)    dout <= cmd;
      if (is_lb && a_uart)   dout <= {24'b0, rx_byte};
      if (is_lw && a_tdat)   dout <= timer;
    end
  end

  // ---------------- UART TX ----------------
  uart_st_t tx_st, tx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick, tx_wr;
  assign tx_tick = (tx_cnt == BIT_END);
  assign tx_wr   = is_sb && a_uart && (tx_st == S_IDLE);
  assign tx_busy = (tx_st != S_IDLE);

  // tx state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_st <= S_IDLE;
    else      tx_st <= tx_nxt;
  end

  // tx next state and line level
  always_comb begin
    tx_nxt  = tx_st;
    ser_txd = 1'b1;
    case (tx_st)
      S_IDLE:  if (tx_wr) tx_nxt = S_START;
      S_START: begin ser_txd = 1'b0; if (tx_tick) tx_nxt = S_DATA; end
      S_DATA:  begin ser_txd = tx_sh[0]; if (tx_tick && tx_bit == 3'd7) tx_nxt = S_STOP; end
      S_STOP:  if (tx_tick) tx_nxt = S_IDLE;
      default: tx_nxt = S_IDLE;
    endcase
  end

  // tx bit timer and shifter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0;
    end else if (tx_st == S_IDLE) begin
      tx_cnt <= '0; tx_bit <= '0;
      if (tx_wr) tx_sh <= din[7:0];
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
      if (tx_tick && tx_st == S_DATA) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // ---------------- UART RX ----------------
  uart_st_t rx_st, rx_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [1:0]    rx_sync;
  logic          rx_prev, rx_s, rx_fall, rx_tick, rx_half, rx_good, rx_rd;
  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;
  assign rx_tick = (rx_cnt == BIT_END);
  assign rx_half = (rx_cnt == HALF_END);
  assign rx_good = (rx_st == S_STOP) && rx_tick && rx_s;
  assign rx_rd   = is_lb && a_uart;

  // rx state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_st <= S_IDLE;
    else      rx_st <= rx_nxt;
  end

  // rx next state: start re-checked at mid-bit, stop must be high
  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      S_IDLE:  if (rx_fall) rx_nxt = S_START;
      S_START: if (rx_half) rx_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nxt = S_STOP;
      S_STOP:  if (rx_tick) rx_nxt = S_IDLE;
      default: rx_nxt = S_IDLE;
    endcase
  end

  // rx sync, bit timer, shifter and ready flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11; rx_prev <= 1'b1; rx_cnt <= '0; rx_bit <= '0;
      rx_sh <= '0; rx_byte <= '0; rx_rdy <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], ser_rxd};
      rx_prev <= rx_s;
      if (rx_st == S_IDLE || rx_st != rx_nxt || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + CW'(1);
      if (rx_st == S_IDLE) rx_bit <= '0;
      else if (rx_st == S_DATA && rx_tick) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_good) rx_byte <= rx_sh;
      if (cmd[1])       rx_rdy <= 1'b0;
      else if (rx_good) rx_rdy <= 1'b1;
      else if (rx_rd)   rx_rdy <= 1'b0;
    end
  end

  // ---------------- Timer ----------------
  logic tmr_ld, tmr_wrap;
  assign tmr_ld   = is_sw && a_tdat;
  assign tmr_wrap = cmd[8] && !cmd[7] && !tmr_ld && (timer == 32'hFFFF_FFFF);

  // clear > load > count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        timer <= '0;
    else if (cmd[7]) timer <= '0;
    else if (tmr_ld) timer <= din;
    else if (cmd[8]) timer <= timer + 32'd1;
  end

  // ---------------- Interrupts ----------------
  logic        req_tmr, req_k1, req_k2;
  logic [31:0] irq_vec;
  assign req_tmr = tmr_wrap & cmd[31];

`ifdef KEY_IRQ_EN
  logic [31:0] k1_vec, k2_vec;
  assign req_k1 = key1_s & cmd[30];
  assign req_k2 = key2_s & cmd[29];

  // key vector registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k1_vec <= '0; k2_vec <= '0;
    end else begin
      if (is_sw && a_k1v) k1_vec <= din;
      if (is_sw && a_k2v) k2_vec <= din;
    end
  end
`else
  assign req_k1 = 1'b0;
  assign req_k2 = 1'b0;
`endif

  // vector select; later assignment has higher priority
  always_comb begin
    irq_vec = irq_addr_o;
`ifdef KEY_IRQ_EN
    if (req_k2) irq_vec = k2_vec;
    if (req_k1) irq_vec = k1_vec;
`endif
    if (req_tmr) irq_vec = tmr_vec;
  end

  // registered request and vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_req_o <= 1'b0; irq_addr_o <= '0;
    end else begin
      irq_req_o  <= cmd[0] & (req_tmr | req_k1 | req_k2);
      irq_addr_o <= irq_vec;
    end
  end

  // ---------------- 7-seg ----------------
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  assign seg7led1 = hex7(seg7data[3:0]);
  assign seg7led2 = hex7(seg7data[7:4]);
endmodule

// File: tb/tb_mips_io_periph.sv
// Directed bench for mips_io_periph (short UART bit period).
module tb_mips_io_periph;
  localparam int CB = 16;
  localparam logic [31:0] B = 32'h0F00_0000;
  localparam logic [3:0] LW = 4'd1, LBU = 4'd3, SW = 4'd4, SB = 4'd5;

  logic        clk = 0, rst = 0;
  logic [31:0] din = '0, addr = '0, dout, irq_addr_o;
  logic [3:0]  mem_ctl = '0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, ser_rxd = 1, ser_txd, led1, led2;
  logic        key1 = 0, key2 = 0, irq_req_o;
  logic [6:0]  seg7led1, seg7led2;
  int checks = 0, failures = 0;

  mips_io_periph #(.BASE(B), .CLKS_PER_BIT(CB)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .mem_ctl(mem_ctl), .dout(dout),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .ser_rxd(ser_rxd), .ser_txd(ser_txd), .seg7led1(seg7led1), .seg7led2(seg7led2),
    .led1(led1), .led2(led2), .key1(key1), .key2(key2),
    .irq_addr_o(irq_addr_o), .irq_req_o(irq_req_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one bus access; returns at the negedge where load data is valid
  task automatic bus(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); mem_ctl = ctl; addr = a; din = d;
    @(negedge clk); mem_ctl = '0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); ser_rxd = 0;
    repeat (CB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin ser_rxd = b[i]; repeat (CB) @(negedge clk); end
    ser_rxd = stop; repeat (CB) @(negedge clk);
    ser_rxd = 1; repeat (4) @(negedge clk);
  endtask

  logic [9:0] txexp;
  logic       seen;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_txd", ser_txd, 1);
    check("rst_irq", irq_req_o, 0);
    check("rst_vec", irq_addr_o, 0);
    check("rst_seg", {seg7led2, seg7led1}, {7'h40, 7'h40});
    rst = 1;

    bus(SB, B + 32'h10, 32'h5A);
    check("seg_5A", {seg7led2, seg7led1}, {7'h12, 7'h08});
    bus(SB, B + 32'h10, 32'hC3);
    check("seg_C3", {seg7led2, seg7led1}, {7'h46, 7'h30});
    bus(LW, B, 0);
    check("status_idle", dout, 0);

    bus(SW, B + 32'h04, 32'h7C);
    check("cmd_pins", {lcd_rs, lcd_rw, lcd_en, led1, led2}, 5'b11111);
    bus(LW, B + 32'h04, 0);
    check("cmd_rd", dout, 32'h7C);
    bus(SW, B + 32'h04, 0);
    bus(SB, B + 32'h0C, 32'hC3);
    check("lcd_data", lcd_data, 8'hC3);
    bus(LW, B + 32'h24, 0);
    check("bad_addr", dout, 0);
    bus(LW, B + 32'h08, 0);
    check("bad_type", dout, 0);

    // UART TX 0x55, second SB mid-frame ignored
    @(negedge clk); mem_ctl = SB; addr = B + 32'h08; din = 32'h55;
    @(negedge clk); mem_ctl = LW; addr = B;
    @(negedge clk);
    check("tx_busy", dout, 32'h4);
    mem_ctl = SB; addr = B + 32'h08; din = 32'hFF;
    @(negedge clk); mem_ctl = '0;
    repeat (5) @(negedge clk);
    txexp = 10'b1_0101_0101_0;  // stop, data msb..lsb, start
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), ser_txd, txexp[i]);
      if (i < 9) repeat (CB) @(negedge clk);
    end
    repeat (CB) @(negedge clk);
    check("tx_idle_line", ser_txd, 1);
    bus(LW, B, 0);
    check("tx_done", dout, 0);

    // UART RX
    rx_frame(8'hA3, 1'b1);
    bus(LW, B, 0);
    check("rx_rdy", dout, 32'h8);
    bus(LBU, B + 32'h08, 0);
    check("rx_byte", dout, 32'hA3);
    bus(LW, B, 0);
    check("rx_rd_clr", dout, 0);
    rx_frame(8'h3C, 1'b1);
    bus(LW, B, 0);
    check("rx_rdy2", dout, 32'h8);
    bus(SW, B + 32'h04, 32'h2);
    bus(LW, B, 0);
    check("rx_flush", dout, 0);
    bus(SW, B + 32'h04, 0);
    rx_frame(8'h81, 1'b0);
    bus(LW, B, 0);
    check("rx_badstop", dout, 0);
    bus(LBU, B + 32'h08, 0);
    check("rx_keep", dout, 32'h3C);

    // timer wrap interrupt
    bus(SW, B + 32'h14, 32'hFFFF_FFFD);
    bus(LW, B + 32'h14, 0);
    check("tmr_ld", dout, 32'hFFFF_FFFD);
    bus(SW, B + 32'h18, 32'h100);
    bus(SW, B + 32'h04, 32'h8000_0101);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (irq_req_o) begin seen = 1; break; end
    end
    check("tmr_irq", seen, 1);
    check("tmr_vec", irq_addr_o, 32'h100);
    @(negedge clk);
    check("tmr_pulse", irq_req_o, 0);
    check("vec_hold", irq_addr_o, 32'h100);
    bus(SW, B + 32'h04, 32'h180);
    bus(LW, B + 32'h14, 0);
    check("tmr_clr", dout, 0);
    bus(SW, B + 32'h04, 0);

    // key interrupt
    bus(SW, B + 32'h1C, 32'h200);
    bus(SW, B + 32'h04, 32'h4000_0001);
    @(negedge clk); key1 = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (irq_req_o) begin seen = 1; break; end
    end
`ifdef KEY_IRQ_EN
    check("k1_irq", seen, 1);
    check("k1_vec", irq_addr_o, 32'h200);
    bus(SW, B + 32'h14, 32'hFFFF_FFFE);
    bus(SW, B + 32'h04, 32'hC000_0101);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (irq_req_o && irq_addr_o == 32'h100) begin seen = 1; break; end
    end
    check("tmr_wins", seen, 1);
    @(negedge clk);
    check("k1_after", irq_addr_o, 32'h200);
`else
    check("k1_noirq", seen, 0);
    check("k1_novec", irq_addr_o, 32'h100);
`endif
    bus(LW, B, 0);
    check("key_status", dout, 32'h2);
    key1 = 0;
    bus(SW, B + 32'h04, 0);

    // reset mid-frame and mid-count
    bus(SW, B + 32'h04, 32'h100);
    bus(SB, B + 32'h08, 32'h0F);
    repeat (3) @(negedge clk);
    check("pre_rst_txd", ser_txd, 0);
    #2 rst = 0;
    #1;
    check("arst_txd", ser_txd, 1);
    check("arst_busy", dut.tx_busy, 0);
    check("arst_tmr", dut.timer, 0);
    check("arst_irq", irq_req_o, 0);
    check("arst_dout", dout, 0);
    @(negedge clk); rst = 1;
    bus(LW, B + 32'h14, 0);
    check("post_tmr", dout, 0);
    bus(LW, B, 0);
    check("post_status", dout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
